alu_shift_unit: RTL

ALU_SHIFT_UNIT -- requirements
Module: alu_shift_unit

---
 rtl/alu_shift_pkg.sv | 29 ++
 rtl/shift_step.sv | 24 ++
 rtl/alu_shift_unit.sv | 90 +++++++++
 3 files changed

// File: rtl/alu_shift_pkg.sv
// Shared definitions for the shift unit: opcode and FSM state encodings,
// plus the helper that turns a raw shift amount into a step count.
package alu_shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam int CNT_W = 4;  // holds 0..8

  // Linear shifts saturate at 8 steps (the result is fully filled by then);
  // rotates only need the amount modulo 8.
  function automatic logic [CNT_W-1:0] load_cnt(input logic [1:0] op,
                                                input logic [7:0] amt);
    if (op == OP_ROR)     return {1'b0, amt[2:0]};
    else if (amt > 8'd8)  return 4'd8;
    else                  return amt[3:0];
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-position combinational shift/rotate step.
//   value_i : current working value
//   op_i    : operation (SLL/SRL/SRA/ROR)
//   value_o : value after exactly one step
module shift_step
  import alu_shift_pkg::*;
(
  input  logic [7:0] value_i,
  input  logic [1:0] op_i,
  output logic [7:0] value_o
);

  always_comb begin
    value_o = value_i;
    case (op_i)
      OP_SLL:  value_o = {value_i[6:0], 1'b0};
      OP_SRL:  value_o = {1'b0, value_i[7:1]};
      OP_SRA:  value_o = {value_i[7], value_i[7:1]};
      OP_ROR:  value_o = {value_i[0], value_i[7:1]};
      default: value_o = value_i;
    endcase
  end

endmodule

// File: rtl/alu_shift_unit.sv
// Multi-cycle shifter: captures an operand on start, applies one shift step
// per clock until the count is exhausted, then registers the result and
// pulses done for one cycle.
//   clk, rst_n  : clock, async active-low reset
//   start_i     : request (accepted only in IDLE)
//   opcode_i    : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   data1_i     : value to shift
//   data2_i     : unsigned shift amount
//   result_o    : last completed result (registered)
//   busy_o      : high while shifting
//   done_o      : one-cycle completion pulse, result valid alongside
module alu_shift_unit
  import alu_shift_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [1:0]            opcode_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  input  logic [DATA_WIDTH-1:0] data2_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  busy_o,
  output logic                  done_o
);

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] step_val;

  shift_step u_step (
    .value_i (work_q),
    .op_i    (op_q),
    .value_o (step_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= 2'b00;
      cnt_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          work_d  = data1_i;
          op_d    = opcode_i;
          cnt_d   = load_cnt(opcode_i, data2_i);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          work_d = step_val;
          cnt_d  = cnt_q - 4'd1;
        end else begin
          result_d = work_q;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign result_o = result_q;
  assign busy_o   = (state_q == ST_SHIFT);
  assign done_o   = (state_q == ST_DONE);

endmodule
